// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

   parameter int MULDIV_WIDTH = 32;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   function automatic int muldiv_cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int MULDIV_CNT_W = muldiv_cnt_w(MULDIV_WIDTH);

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial-subtract the divisor.
module muldiv_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem < divisor on entry, so the shifted value always fits in WIDTH+1 bits
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      if (!diff[WIDTH]) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = shifted[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers, start/busy/done handshake and flush.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide stays iterative.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  muldiv_op_t       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = muldiv_cnt_w(WIDTH);

   state_t               state;
   logic [CNT_W-1:0]     count;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     opnd;
   logic [WIDTH-1:0]     a_raw;
   logic                 is_div, neg_q, neg_r, div0;

   logic                 signed_op, is_div_op, a_neg, b_neg;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH-1:0]     div_rem, div_quo;
   logic [WIDTH-1:0]     res_hi, res_lo;
   logic [WIDTH-1:0]     q, r;

   assign signed_op = (op == MULT) || (op == DIV);
   assign is_div_op = (op == DIV) || (op == DIVU);
   assign a_neg     = signed_op & a[WIDTH-1];
   assign b_neg     = signed_op & b[WIDTH-1];
   assign a_abs     = a_neg ? -a : a;
   assign b_abs     = b_neg ? -b : b;

   // Shift-add multiply: multiplier sits in the low half and shifts out as product bits shift in
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem      (acc[2*WIDTH-1:WIDTH]),
      .quo      (acc[WIDTH-1:0]),
      .divisor  (opnd),
      .rem_next (div_rem),
      .quo_next (div_quo)
   );

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif

   // Sign fix-up on magnitudes; divide-by-zero overrides the raw restoring result
   always_comb begin
      q      = acc[WIDTH-1:0];
      r      = acc[2*WIDTH-1:WIDTH];
      res_hi = acc[2*WIDTH-1:WIDTH];
      res_lo = acc[WIDTH-1:0];
      if (div0) begin
         res_hi = a_raw;
         res_lo = '1;
      end else if (is_div) begin
         res_lo = neg_q ? -q : q;
         res_hi = neg_r ? -r : r;
      end else if (neg_q) begin
         {res_hi, res_lo} = -acc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         count  <= '0;
         acc    <= '0;
         opnd   <= '0;
         a_raw  <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  case (op)
                     MTHI: begin
                        hi   <= a;
                        done <= 1'b1;
                     end
                     MTLO: begin
                        lo   <= a;
                        done <= 1'b1;
                     end
                     MULT, MULTU, DIV, DIVU: begin
                        is_div <= is_div_op;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div0   <= is_div_op && (b == '0);
                        a_raw  <= a;
                        opnd   <= b_abs;
                        count  <= '0;
                        busy   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        if (!is_div_op) begin
                           acc   <= fast_prod;
                           state <= FIX;
                        end else begin
                           acc   <= {{WIDTH{1'b0}}, a_abs};
                           state <= CALC;
                        end
`else
                        acc   <= {{WIDTH{1'b0}}, a_abs};
                        state <= CALC;
`endif
                     end
                     default: ;
                  endcase
               end
            end
            CALC: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc   <= is_div ? {div_rem, div_quo} : mul_next;
                  count <= count + CNT_W'(1);
                  if (count == CNT_W'(WIDTH - 1))
                     state <= FIX;
               end
            end
            FIX: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (!flush) begin
                  hi   <= res_hi;
                  lo   <= res_lo;
                  done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): latency, results, specials, flush, reset, busy-issue.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   muldiv_op_t  op = MULT;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;
   logic [63:0] sb[$];
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] cur_hi, input logic [31:0] cur_lo);
      logic signed [63:0] sp;
      logic signed [31:0] sq, sr;
      case (o)
         MULT: begin
            sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            return sp;
         end
         MULTU: return {32'd0, x} * {32'd0, y};
         DIVU: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            return {x % y, x / y};
         end
         DIV: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, x};
            sq = $signed(x) / $signed(y);
            sr = $signed(x) % $signed(y);
            return {sr, sq};
         end
         MTHI: return {x, cur_lo};
         MTLO: return {cur_hi, x};
         default: return {cur_hi, cur_lo};
      endcase
   endfunction

   task automatic issue(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Issue one op, wait for done (bounded), then check result, latency and busy span.
   task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y, input string name);
      logic [63:0] e;
      int n, nb, exp_n, exp_nb;
      logic seen;
      e = model(o, x, y, model_hi, model_lo);
      sb.push_back(e);
      {model_hi, model_lo} = e;
      if (o == MTHI || o == MTLO) begin exp_n = 1; exp_nb = 0; end
`ifdef MULDIV_FAST_MUL_EN
      else if (o == MULT || o == MULTU) begin exp_n = 2; exp_nb = 1; end
`endif
      else begin exp_n = 34; exp_nb = 33; end
      issue(o, x, y);
      n = 0; nb = 0; seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (done) seen = 1'b1;
      end
      e = sb.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: no done within %0d cycles", name, n);
      end else begin
         checks += 4;
         if (hi !== e[63:32]) begin errors++; $display("FAIL %s hi: got %h want %h", name, hi, e[63:32]); end
         if (lo !== e[31:0])  begin errors++; $display("FAIL %s lo: got %h want %h", name, lo, e[31:0]); end
         if (n !== exp_n)     begin errors++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_n); end
         if (nb !== exp_nb)   begin errors++; $display("FAIL %s busy cycles: got %0d want %0d", name, nb, exp_nb); end
         @(negedge clk);
         if (done !== 1'b0) begin errors++; $display("FAIL %s done width: got %b want 0", name, done); end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks += 4;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
      if (hi !== 32'd0)  begin errors++; $display("FAIL reset hi: got %h want 0", hi); end
      if (lo !== 32'd0)  begin errors++; $display("FAIL reset lo: got %h want 0", lo); end
      reset = 1'b1;
      model_hi = '0; model_lo = '0;
   endtask

   task automatic test_mult;
      run_op(MULT,  32'hFFFFFFFD, 32'd5,        "mult_neg_pos");
      run_op(MULT,  32'hFFFFFFF9, 32'hFFFFFFF7, "mult_neg_neg");
      run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
      run_op(MULT,  32'h80000000, 32'h80000000, "mult_minmin");
   endtask

   task automatic test_div;
      run_op(DIVU, 32'd100,      32'd7,        "divu_100_7");
      run_op(DIV,  32'hFFFFFFF9, 32'd2,        "div_m7_2");
      run_op(DIV,  32'd7,        32'hFFFFFFFE, "div_7_m2");
      run_op(DIVU, 32'hFFFFFFFF, 32'd1,        "divu_max_1");
   endtask

   task automatic test_div_special;
      run_op(DIV,  32'd5,        32'd0,        "div_by_zero");
      run_op(DIV,  32'hFFFFFFF0, 32'd0,        "div_neg_by_zero");
      run_op(DIVU, 32'h89ABCDEF, 32'd0,        "divu_by_zero");
      run_op(DIV,  32'h80000000, 32'hFFFFFFFF, "div_overflow");
   endtask

   task automatic test_mthi_mtlo;
      run_op(MTHI, 32'h12345678, 32'd0, "mthi");
      run_op(MTLO, 32'h9ABCDEF0, 32'd0, "mtlo");
   endtask

   task automatic test_flush;
      logic seen;
      issue(DIVU, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush busy: got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL flush done: got %b want 0", done); end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
      checks += 3;
      if (seen)            begin errors++; $display("FAIL flush late done: got 1 want 0"); end
      if (hi !== model_hi) begin errors++; $display("FAIL flush hi: got %h want %h", hi, model_hi); end
      if (lo !== model_lo) begin errors++; $display("FAIL flush lo: got %h want %h", lo, model_lo); end
   endtask

   task automatic test_flush_start_idle;
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = MTLO; a = 32'hCAFEF00D;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      checks += 3;
      if (done !== 1'b0)   begin errors++; $display("FAIL flush_start done: got %b want 0", done); end
      if (busy !== 1'b0)   begin errors++; $display("FAIL flush_start busy: got %b want 0", busy); end
      if (lo !== model_lo) begin errors++; $display("FAIL flush_start lo: got %h want %h", lo, model_lo); end
   endtask

   task automatic test_reset_mid;
      issue(DIVU, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      model_hi = '0; model_lo = '0;
      @(negedge clk);
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b want 0", busy); end
      if (hi !== 32'd0)  begin errors++; $display("FAIL reset_mid hi: got %h want 0", hi); end
      if (lo !== 32'd0)  begin errors++; $display("FAIL reset_mid lo: got %h want 0", lo); end
   endtask

   task automatic test_start_while_busy;
      logic [63:0] e;
      int n, ndone;
      e = model(DIVU, 32'd100, 32'd7, model_hi, model_lo);
      sb.push_back(e);
      {model_hi, model_lo} = e;
      issue(DIVU, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      start = 1'b1; op = MTHI; a = 32'hDEADBEEF;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0; ndone = 0;
      repeat (60) begin
         @(negedge clk);
         n++;
         if (done) ndone++;
      end
      e = sb.pop_front();
      checks += 3;
      if (ndone !== 1)        begin errors++; $display("FAIL busy_start done count: got %0d want 1", ndone); end
      if (hi !== e[63:32])    begin errors++; $display("FAIL busy_start hi: got %h want %h", hi, e[63:32]); end
      if (lo !== e[31:0])     begin errors++; $display("FAIL busy_start lo: got %h want %h", lo, e[31:0]); end
   endtask

   task automatic test_back_to_back;
      muldiv_op_t o;
      logic [31:0] x, y;
      for (int i = 0; i < 12; i++) begin
         o = muldiv_op_t'($urandom_range(0, 3));
         x = $urandom;
         y = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         if (i % 3 == 1) y = 32'($urandom_range(1, 15));
         run_op(o, x, y, "random");
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_div_special;
      test_mthi_mtlo;
      test_flush;
      test_flush_start_idle;
      test_reset_mid;
      test_start_while_busy;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
